// File: rtl/nibbler_pkg.sv
// rtl/nibbler_pkg.sv - shared types and port ids for the Nibbler IN-side peripheral
// Contents:
//   nibble_t      4-bit data nibble
//   IN_PORT0..2   rd_sel codes of the three IN ports
//   IN_PORT_NONE  rd_sel code that addresses no port
//   NUM_IN_PORTS  number of pushbutton banks / IN ports
package nibbler_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [1:0] IN_PORT0     = 2'd0;
  localparam logic [1:0] IN_PORT1     = 2'd1;
  localparam logic [1:0] IN_PORT2     = 2'd2;
  localparam logic [1:0] IN_PORT_NONE = 2'd3;
  localparam int         NUM_IN_PORTS = 3;

endpackage

// File: rtl/nibbler_debounce_bit.sv
// rtl/nibbler_debounce_bit.sv - two-flop synchroniser plus counting debouncer for one button bit
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   raw    in   asynchronous button level
//   db     out  debounced level
//   rise   out  high while db is about to go 0->1 at the coming edge
module nibbler_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // cnt holds the number of consecutive earlier mismatch edges, so the
  // DEBOUNCE_CYCLES-th mismatching edge is the one that moves db.
  assign flip = (s2 != db) && (cnt == CNT_LAST);
  assign rise = flip && s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (flip) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nibbler_in_port.sv
// rtl/nibbler_in_port.sv - conditions three 4-bit pushbutton banks into Nibbler IN_0..IN_2
// Optional feature macro: NIBBLER_IN_STICKY_EN (per-bit sticky press flags cleared by IN reads)
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   BTN_0..2     in   raw asynchronous pushbutton banks
//   rd_en        in   CPU IN-instruction read strobe
//   rd_sel       in   port being read (3 = none)
//   IN_0..2      out  conditioned nibbles
//   press        out  one-cycle pulse when any debounced bit rises
module nibbler_in_port
  import nibbler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] BTN_0,
  input  logic [3:0] BTN_1,
  input  logic [3:0] BTN_2,
  input  logic       rd_en,
  input  logic [1:0] rd_sel,
  output logic [3:0] IN_0,
  output logic [3:0] IN_1,
  output logic [3:0] IN_2,
  output logic       press
);

  localparam int NBITS = NUM_IN_PORTS * 4;

  logic [NBITS-1:0] raw;
  logic [NBITS-1:0] db;
  logic [NBITS-1:0] rise;
  logic [NBITS-1:0] vis;

  assign raw = {BTN_2, BTN_1, BTN_0};

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    nibbler_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .db   (db[i]),
      .rise (rise[i])
    );
  end

  // rise is the pre-edge view of a 0->1 flip, so registering it lines the
  // pulse up with the first cycle the new level is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      press <= 1'b0;
    end else begin
      press <= |rise;
    end
  end

`ifdef NIBBLER_IN_STICKY_EN
  localparam logic [1:0] PORT_ID [NUM_IN_PORTS] = '{IN_PORT0, IN_PORT1, IN_PORT2};

  logic [NBITS-1:0] sticky;
  logic [NBITS-1:0] clr;

  always_comb begin
    clr = '0;
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      if (rd_en && (rd_sel != IN_PORT_NONE) && (rd_sel == PORT_ID[k])) begin
        clr[4*k +: 4] = 4'hF;
      end
    end
  end

  // A rise on the clearing edge is a fresh press and must survive the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky <= '0;
    end else begin
      sticky <= rise | (sticky & ~clr);
    end
  end

  assign vis = db | sticky;
`else
  logic unused_rd;
  assign unused_rd = &{1'b0, rd_en, rd_sel};
  assign vis = db;
`endif

  assign IN_0 = nibble_t'(vis[3:0]);
  assign IN_1 = nibble_t'(vis[7:4]);
  assign IN_2 = nibble_t'(vis[11:8]);

endmodule

// File: tb/tb_nibbler_in_port.sv
// tb/tb_nibbler_in_port.sv - scoreboard bench for nibbler_in_port with a window-based reference model
module tb_nibbler_in_port;

  localparam int D = 4;

  typedef struct packed {
    logic [3:0] in0;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       press;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] BTN_0 = 4'h0;
  logic [3:0] BTN_1 = 4'h0;
  logic [3:0] BTN_2 = 4'h0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_sel = 2'd3;
  logic [3:0] IN_0;
  logic [3:0] IN_1;
  logic [3:0] IN_2;
  logic       press;

  int checks = 0;
  int errors = 0;

  exp_t expq[$];

  logic [3:0] cur0 = 4'h0;
  logic [3:0] cur1 = 4'h0;
  logic [3:0] cur2 = 4'h0;

  // reference model state: raw delayed by the two synchroniser stages,
  // debounced levels, sticky flags, and per-bit history of synchronised samples
  logic [11:0] m_d1 = '0;
  logic [11:0] m_d2 = '0;
  logic [11:0] m_db = '0;
  logic [11:0] m_sticky = '0;
  logic [31:0] m_hist [12];
  int          m_n [12];

  nibbler_in_port #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .BTN_0 (BTN_0),
    .BTN_1 (BTN_1),
    .BTN_2 (BTN_2),
    .rd_en (rd_en),
    .rd_sel(rd_sel),
    .IN_0  (IN_0),
    .IN_1  (IN_1),
    .IN_2  (IN_2),
    .press (press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // A debounced bit takes value v once the last D synchronised samples taken
  // since reset or since its previous change all equal v and differ from it.
  task automatic model_step(input logic rst, input logic [11:0] raw, input logic re,
                            input logic [1:0] rs, output exp_t e);
    logic [11:0] s2;
    logic [11:0] rose;
    logic [11:0] vis;
    logic [D-1:0] want;
    rose = '0;
    if (rst) begin
      m_d1 = '0;
      m_d2 = '0;
      m_db = '0;
      m_sticky = '0;
      for (int i = 0; i < 12; i++) begin
        m_hist[i] = '0;
        m_n[i] = 0;
      end
    end else begin
      s2   = m_d2;
      m_d2 = m_d1;
      m_d1 = raw;
      for (int i = 0; i < 12; i++) begin
        m_hist[i] = {m_hist[i][30:0], s2[i]};
        if (m_n[i] < D) m_n[i]++;
        want = {D{~m_db[i]}};
        if (m_n[i] >= D && m_hist[i][D-1:0] == want) begin
          m_db[i] = s2[i];
          rose[i] = s2[i];
          m_n[i]  = 0;
        end
      end
`ifdef NIBBLER_IN_STICKY_EN
      for (int k = 0; k < 3; k++) begin
        if (re && rs == k) m_sticky[4*k +: 4] = 4'h0;
      end
      m_sticky = m_sticky | rose;
`endif
    end
    vis     = m_db | m_sticky;
    e.in0   = vis[3:0];
    e.in1   = vis[7:4];
    e.in2   = vis[11:8];
    e.press = |rose;
  endtask

  task automatic tick(input logic rst, input logic re, input logic [1:0] rs);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    BTN_0  = cur0;
    BTN_1  = cur1;
    BTN_2  = cur2;
    rd_en  = re;
    rd_sel = rs;
    model_step(rst, {cur2, cur1, cur0}, re, rs, e);
    expq.push_back(e);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'd3);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // monitor: every edge with a pending expectation is compared
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("IN_0", {28'd0, IN_0}, {28'd0, e.in0});
        chk("IN_1", {28'd0, IN_1}, {28'd0, e.in1});
        chk("IN_2", {28'd0, IN_2}, {28'd0, e.in2});
        chk("press", {31'd0, press}, {31'd0, e.press});
      end
    end
  end

  initial begin
    logic [3:0] bounce [4];
    logic [3:0] tog;
    logic       rst;
    for (int i = 0; i < 12; i++) begin
      m_hist[i] = '0;
      m_n[i] = 0;
    end

    // 1: reset with BTN_0 held, then 6-edge latency and one press pulse
    cur0 = 4'hF;
    tick(1'b1, 1'b0, 2'd3);
    after_edge();
    chk("reset_in0", {28'd0, IN_0}, 32'd0);
    chk("reset_press", {31'd0, press}, 32'd0);
    tick(1'b1, 1'b0, 2'd3);
    for (int n = 1; n <= 7; n++) begin
      tick(1'b0, 1'b0, 2'd3);
      after_edge();
      if (n == 5) chk("s1_edge5", {28'd0, IN_0}, 32'd0);
      if (n == 6) begin
        chk("s1_edge6", {28'd0, IN_0}, 32'hF);
        chk("s1_press", {31'd0, press}, 32'd1);
      end
      if (n == 7) chk("s1_press_end", {31'd0, press}, 32'd0);
    end
    hold(4);

    // 2: single bit on bank 1
    cur1 = 4'b0100;
    for (int n = 1; n <= 6; n++) begin
      tick(1'b0, 1'b0, 2'd3);
      after_edge();
      if (n == 5) chk("s2_edge5", {28'd0, IN_1}, 32'd0);
      if (n == 6) chk("s2_edge6", {28'd0, IN_1}, 32'h4);
    end
    hold(4);

    // 3: one-cycle bounce on BTN_2[0] must not leak through
    bounce[0] = 4'h1; bounce[1] = 4'h0; bounce[2] = 4'h1; bounce[3] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      cur2 = bounce[i];
      tick(1'b0, 1'b0, 2'd3);
    end
    cur2 = 4'h1;
    for (int n = 1; n <= 8; n++) begin
      tick(1'b0, 1'b0, 2'd3);
      after_edge();
      if (n == 5) chk("s3_edge5", {28'd0, IN_2}, 32'd0);
      if (n == 6) chk("s3_edge6", {28'd0, IN_2}, 32'h1);
    end

    // 4: release never pulses press (monitor checks press every edge)
    cur0 = 4'h0;
    for (int n = 1; n <= 8; n++) begin
      tick(1'b0, 1'b0, 2'd3);
      after_edge();
      if (n == 5) chk("s4_edge5", {28'd0, IN_0}, 32'hF);
      if (n == 6) chk("s4_edge6", {28'd0, IN_0}, 32'd0);
    end

    // 5: reset in the middle of a debounce discards the partial count
    cur1 = 4'h0;
    hold(8);
    cur1 = 4'b0110;
    hold(3);
    tick(1'b1, 1'b0, 2'd3);
    for (int n = 1; n <= 7; n++) begin
      tick(1'b0, 1'b0, 2'd3);
      after_edge();
      if (n == 5) chk("s5_edge5", {28'd0, IN_1}, 32'd0);
      if (n == 6) chk("s5_edge6", {28'd0, IN_1}, 32'h6);
    end

`ifdef NIBBLER_IN_STICKY_EN
    // 6: sticky capture, foreign read, own read, clear racing a new rise
    cur1 = 4'h0;
    cur2 = 4'h0;
    hold(10);
    cur0 = 4'b1000;
    hold(6);
    cur0 = 4'h0;
    hold(14);
    after_edge();
    chk("s6_sticky_held", {28'd0, IN_0}, 32'h8);
    tick(1'b0, 1'b1, 2'd1);
    after_edge();
    chk("s6_other_read", {28'd0, IN_0}, 32'h8);
    tick(1'b0, 1'b1, 2'd0);
    after_edge();
    chk("s6_own_read", {28'd0, IN_0}, 32'h0);
    cur0 = 4'b1000;
    hold(5);
    tick(1'b0, 1'b1, 2'd0);
    cur0 = 4'h0;
    hold(14);
    after_edge();
    chk("s6_rise_wins", {28'd0, IN_0}, 32'h8);
    tick(1'b0, 1'b1, 2'd0);
`endif

    // random phase: sparse toggles, occasional reset and reads
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 9) == 0);
      cur0 = cur0 ^ tog;
      for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 9) == 0);
      cur1 = cur1 ^ tog;
      for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 4) == 0);
      cur2 = cur2 ^ tog;
      rst = ($urandom_range(0, 299) == 0);
      tick(rst, 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
    end
    hold(2);
    after_edge();
    chk("queue_drained", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
